stepdown_drv_seq: RTL and testbench

- Synchronous sequencer for the step-down converter's power-stage driver.
- Converts the loop PWM demand into non-overlapping high-side (HS) and low-side (LS) gate commands that feed the driver's 5V inverter chains.
- Enforces programmable dead time, minimum on/off times, maximum duty, diode-emulation LS turn-off, and cycle-by-cycle overcurrent with a latched fault.

---
 rtl/stepdown_drv_seq.sv | 141 ++++++++++++++
 tb/tb_stepdown_drv_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stepdown_drv_seq.sv
// Step-down power-stage gate sequencer: turns loop PWM demand into non-overlapping
// HS/LS commands with dead time, min/max on-time, diode emulation and latched OCP.
module stepdown_drv_seq #(
    parameter int DT_W      = 4,
    parameter int MIN_ON    = 3,
    parameter int MIN_OFF   = 2,
    parameter int MAX_ON    = 60,
    parameter int BLANK     = 2,
    parameter int OCP_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    input  logic            en,
    input  logic            pwm_in,
    input  logic            ocp,
    input  logic            zcd,
    input  logic [DT_W-1:0] dt_hl,
    input  logic [DT_W-1:0] dt_lh,
    output logic            hs_on,
    output logic            ls_on,
    output logic            fault,
    output logic [2:0]      state
);
    localparam int ON_W  = $clog2(MAX_ON + 1);
    localparam int OFF_W = $clog2(MIN_OFF + 1);
    localparam int OCP_W = $clog2(OCP_LIMIT + 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_DT_HL = 3'd1,
        S_HS_ON = 3'd2,
        S_DT_LH = 3'd3,
        S_LS_ON = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t            cur, nxt;
    logic [DT_W-1:0]   dt_cnt;
    logic [ON_W-1:0]   on_cnt;
    logic [OFF_W-1:0]  off_cnt;
    logic [OCP_W-1:0]  ocp_cnt, ocp_inc;
    logic              pend;
    logic              ocp_hit, norm_hit, max_hit;

    // Supply/substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    assign state = cur;

    assign ocp_hit  = ocp && (on_cnt > ON_W'(BLANK));
    assign norm_hit = !pwm_in && (on_cnt >= ON_W'(MIN_ON));
    assign max_hit  = on_cnt >= ON_W'(MAX_ON);
    assign ocp_inc  = (ocp_cnt == OCP_W'(OCP_LIMIT)) ? ocp_cnt : ocp_cnt + OCP_W'(1);

    always_comb begin
        nxt = cur;
        if (!en) begin
            nxt = S_OFF;
        end else begin
            case (cur)
                S_OFF:   if (pwm_in) nxt = S_DT_HL;
                S_DT_HL: if (dt_cnt <= DT_W'(1)) nxt = S_HS_ON;
                S_HS_ON: begin
                    // OCP wins over MIN_ON and over a coincident normal/max exit
                    if (ocp_hit)
                        nxt = (ocp_inc == OCP_W'(OCP_LIMIT)) ? S_FAULT : S_DT_LH;
                    else if (norm_hit || max_hit)
                        nxt = S_DT_LH;
                end
                S_DT_LH: if (dt_cnt <= DT_W'(1)) nxt = S_LS_ON;
                S_LS_ON: begin
                    if (zcd)
                        nxt = S_OFF;
                    else if ((pwm_in || pend) && off_cnt >= OFF_W'(MIN_OFF))
                        nxt = S_DT_HL;
                end
                S_FAULT: nxt = S_FAULT;
                default: nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_OFF;
            hs_on   <= 1'b0;
            ls_on   <= 1'b0;
            fault   <= 1'b0;
            dt_cnt  <= '0;
            on_cnt  <= '0;
            off_cnt <= '0;
            ocp_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            cur   <= nxt;
            hs_on <= (nxt == S_HS_ON);
            ls_on <= (nxt == S_LS_ON);
            fault <= (nxt == S_FAULT);
            if (!en) begin
                dt_cnt  <= '0;
                on_cnt  <= '0;
                off_cnt <= '0;
                ocp_cnt <= '0;
                pend    <= 1'b0;
            end else begin
                // Dead time latched on entry; zero still yields one both-off cycle
                if (nxt == S_DT_HL && cur != S_DT_HL)
                    dt_cnt <= (dt_hl == '0) ? DT_W'(1) : dt_hl;
                else if (nxt == S_DT_LH && cur != S_DT_LH)
                    dt_cnt <= (dt_lh == '0) ? DT_W'(1) : dt_lh;
                else if ((cur == S_DT_HL || cur == S_DT_LH) && dt_cnt != '0)
                    dt_cnt <= dt_cnt - DT_W'(1);

                if (nxt == S_HS_ON)
                    on_cnt <= (cur != S_HS_ON) ? ON_W'(1) :
                              (max_hit ? on_cnt : on_cnt + ON_W'(1));
                else
                    on_cnt <= '0;

                if (nxt == S_LS_ON)
                    off_cnt <= (cur != S_LS_ON) ? OFF_W'(1) :
                               ((off_cnt >= OFF_W'(MIN_OFF)) ? off_cnt : off_cnt + OFF_W'(1));
                else
                    off_cnt <= '0;

                pend <= (cur == S_LS_ON && nxt == S_LS_ON) ? (pend | pwm_in) : 1'b0;

                if (cur == S_HS_ON) begin
                    if (ocp_hit)
                        ocp_cnt <= ocp_inc;
                    else if (norm_hit)
                        ocp_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_stepdown_drv_seq.sv
// Bench for stepdown_drv_seq: directed pulse-timing scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_stepdown_drv_seq;
    localparam int DT_W = 4, MIN_ON = 3, MIN_OFF = 2, MAX_ON = 60, BLANK = 2, OCP_LIMIT = 4;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pwm_in = 1'b0, ocp = 1'b0, zcd = 1'b0;
    logic [DT_W-1:0] dt_hl = '0, dt_lh = '0;
    logic hs_on, ls_on, fault;
    logic [2:0] state;

    int n_chk = 0, n_fail = 0;
    int m_st = 0, m_left = 0, m_on = 0, m_off = 0, m_ocp = 0;
    bit m_pend = 0;
    bit p_hs = 0, p_ls = 0;

    always #5 clk = ~clk;

    stepdown_drv_seq #(.DT_W(DT_W), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .MAX_ON(MAX_ON),
                       .BLANK(BLANK), .OCP_LIMIT(OCP_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .pwm_in(pwm_in), .ocp(ocp), .zcd(zcd), .dt_hl(dt_hl), .dt_lh(dt_lh),
        .hs_on(hs_on), .ls_on(ls_on), .fault(fault), .state(state));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model phases: 0 idle, 1 dead time before HS, 2 HS, 3 dead time before LS, 4 LS, 5 fault.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            m_st = 0; m_left = 0; m_on = 0; m_off = 0; m_ocp = 0; m_pend = 0;
        end else begin
            case (m_st)
                0: if (pwm_in) begin m_st = 1; m_left = (dt_hl == 0) ? 1 : int'(dt_hl); end
                1: begin m_left--; if (m_left == 0) begin m_st = 2; m_on = 1; end end
                2: begin
                    if (ocp && m_on > BLANK) begin
                        m_ocp++;
                        if (m_ocp == OCP_LIMIT) m_st = 5;
                        else begin m_st = 3; m_left = (dt_lh == 0) ? 1 : int'(dt_lh); end
                    end else if ((!pwm_in && m_on >= MIN_ON) || m_on >= MAX_ON) begin
                        if (!pwm_in && m_on >= MIN_ON) m_ocp = 0;
                        m_st = 3; m_left = (dt_lh == 0) ? 1 : int'(dt_lh);
                    end else m_on++;
                end
                3: begin m_left--; if (m_left == 0) begin m_st = 4; m_off = 1; m_pend = 0; end end
                4: begin
                    if (zcd) m_st = 0;
                    else if ((pwm_in || m_pend) && m_off >= MIN_OFF) begin
                        m_st = 1; m_left = (dt_hl == 0) ? 1 : int'(dt_hl);
                    end else begin
                        if (pwm_in) m_pend = 1;
                        m_off++;
                    end
                end
                default: m_st = 5;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", state, m_st);
            chk("hs_on", hs_on, m_st == 2);
            chk("ls_on", ls_on, m_st == 4);
            chk("fault", fault, m_st == 5);
            chk("overlap", hs_on & ls_on, 0);
            chk("no_deadtime", (p_hs & ls_on) | (p_ls & hs_on), 0);
            p_hs = hs_on; p_ls = ls_on;
        end else begin
            p_hs = 0; p_ls = 0;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(int s);
        case (s)
            0: return hs_on;
            1: return ls_on;
            default: return fault;
        endcase
    endfunction

    // Cycles until the selected output reaches v; an expired bound counts as a failure.
    task automatic wait_val(string nm, int s, logic v, int lim, output int n);
        n = 0;
        while (sig(s) !== v && n < lim) begin tick(); n++; end
        if (sig(s) !== v) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout after %0d cycles, level %0d never seen", nm, lim, v);
        end
    endtask

    task automatic restart();
        en = 1'b0; tick(); en = 1'b1; tick();
    endtask

    initial begin
        int n, w;
        tick(2);
        chk("rst_hs", hs_on, 0); chk("rst_ls", ls_on, 0);
        chk("rst_fault", fault, 0); chk("rst_state", state, 0);
        rst_n = 1'b1; en = 1'b1; dt_hl = 4'd3; dt_lh = 4'd2;
        tick(3);

        // Normal pulse: 1+dt_hl latency, 10-cycle HS, 2-cycle gap, then LS.
        pwm_in = 1'b1;
        wait_val("t1_rise", 0, 1'b1, 20, n); chk("t1_rise_delay", n, 4);
        chk("t1_model_hs", m_st, 2);
        tick(9); pwm_in = 1'b0;
        wait_val("t1_fall", 0, 1'b0, 20, n); chk("t1_hs_width", 9 + n, 10);
        wait_val("t1_ls", 1, 1'b1, 20, n); chk("t1_gap", n, 2);

        // One-cycle demand still gives MIN_ON.
        restart();
        pwm_in = 1'b1; tick(); pwm_in = 1'b0;
        wait_val("t2_rise", 0, 1'b1, 20, n);
        wait_val("t2_fall", 0, 1'b0, 20, n); chk("t2_min_on", n, MIN_ON);

        // Stuck demand: MAX_ON, dead time, MIN_OFF LS, dead time, next HS.
        restart();
        pwm_in = 1'b1;
        wait_val("t3_rise", 0, 1'b1, 20, n);
        wait_val("t3_fall", 0, 1'b0, 100, n); chk("t3_max_on", n, MAX_ON);
        wait_val("t3_ls", 1, 1'b1, 20, n); chk("t3_gap", n, 2); chk("t3_state_ls", state, 4);
        wait_val("t3_ls_off", 1, 1'b0, 20, n); chk("t3_min_off", n, MIN_OFF);
        chk("t3_state_dthl", state, 1);
        wait_val("t3_rise2", 0, 1'b1, 20, n); chk("t3_dt_hl", n, 3);

        // Continuous OCP: each pulse cut at BLANK+1, fourth latches fault.
        restart();
        ocp = 1'b1; pwm_in = 1'b1;
        for (int i = 0; i < OCP_LIMIT; i++) begin
            wait_val("t4_rise", 0, 1'b1, 40, n);
            wait_val("t4_fall", 0, 1'b0, 40, n); chk("t4_ocp_width", n, 3);
            if (i < OCP_LIMIT - 1) chk("t4_no_fault_yet", fault, 0);
        end
        chk("t4_fault", fault, 1); chk("t4_state", state, 5);
        chk("t4_ls", ls_on, 0); chk("t4_model_fault", m_st, 5);
        tick(3); chk("t4_fault_held", fault, 1);
        en = 1'b0; tick();
        chk("t4_clear_fault", fault, 0); chk("t4_clear_state", state, 0);
        en = 1'b1; ocp = 1'b0; pwm_in = 1'b0; tick();

        // Diode emulation: zcd beats pwm_in in LS_ON.
        pwm_in = 1'b1; tick(); pwm_in = 1'b0;
        wait_val("t5_ls", 1, 1'b1, 40, n);
        zcd = 1'b1; pwm_in = 1'b1; tick();
        chk("t5_ls_off", ls_on, 0); chk("t5_state_off", state, 0);
        zcd = 1'b0; tick(); chk("t5_dt_hl", state, 1);
        pwm_in = 1'b0;
        wait_val("t5_ls2", 1, 1'b1, 40, n);

        // Asynchronous reset mid-pulse.
        restart();
        pwm_in = 1'b1;
        wait_val("t6_rise", 0, 1'b1, 20, n);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_hs", hs_on, 0); chk("t6_async_state", state, 0);
        @(negedge clk); pwm_in = 1'b0; rst_n = 1'b1;
        tick(); chk("t6_state", state, 0); chk("t6_fault", fault, 0);

        // Random sweep against the model, dead times including 0.
        w = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 99) < 15) pwm_in = ~pwm_in;
            ocp = ($urandom_range(0, 29) == 0);
            zcd = ($urandom_range(0, 11) == 0);
            en  = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 49) == 0) begin
                dt_hl = DT_W'($urandom_range(0, 15));
                dt_lh = DT_W'($urandom_range(0, 3));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
